// File: rtl/bounded_counter_pkg.sv
// Shared types and defaults for the bounded up/down counter.
// Boundary modes, FSM states and the reserved-mode decode live here.
package bounded_counter_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STEP_W = 4;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'd0,
      MODE_SAT     = 2'd1,
      MODE_ONESHOT = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   // The reserved encoding saturates so an unprogrammed mode can never run away.
   function automatic mode_e decode_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_SAT : mode_e'(m);
   endfunction

endpackage

// File: rtl/bounded_counter_next.sv
// Next-value and bound-crossing calculation for bounded_counter.
// Purely combinational (0 cycles); no flow control, result consumed by the caller's register.
module bounded_counter_next
   import bounded_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic [WIDTH-1:0]  count,
   input  logic [STEP_W-1:0] step,
   input  logic              up_down,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  lo_bound,
   input  logic [WIDTH-1:0]  hi_bound,
   output logic [WIDTH-1:0]  next_val,
   output logic              up_cross,
   output logic              dn_cross,
   output logic              to_done
);

   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] cur;
   logic [WIDTH:0] cand;
   mode_e          m;

   always_comb begin
      step_ext = (WIDTH+1)'(step);
      cur      = {1'b0, count};
      m        = decode_mode(mode);
      cand     = up_down ? (cur + step_ext) : (cur - step_ext);
      next_val = cand[WIDTH-1:0];
      up_cross = 1'b0;
      dn_cross = 1'b0;
      to_done  = 1'b0;

      // A zero step is a hold, even when the count sits outside freshly changed bounds.
      if (step != '0) begin
         if (up_down)
            up_cross = (cand > {1'b0, hi_bound});
         else
            dn_cross = cand[WIDTH] || (cand[WIDTH-1:0] < lo_bound);
      end

      if (up_cross) begin
         case (m)
            MODE_WRAP:    next_val = lo_bound;
            MODE_ONESHOT: begin
               next_val = hi_bound;
               to_done  = 1'b1;
            end
            default:      next_val = hi_bound;
         endcase
      end else if (dn_cross) begin
         case (m)
            MODE_WRAP:    next_val = hi_bound;
            MODE_ONESHOT: begin
               next_val = lo_bound;
               to_done  = 1'b1;
            end
            default:      next_val = lo_bound;
         endcase
      end
   end

endmodule

// File: rtl/bounded_counter.sv
// Bounded up/down counter with wrap/saturate/one-shot boundary handling and status flags.
// Count, ovf/unf and done update 1 cycle after the edge; no backpressure, ce gates counting.
module bounded_counter
   import bounded_counter_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              load_n,
   input  logic              up_down,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  lo_bound,
   input  logic [WIDTH-1:0]  hi_bound,
   input  logic [WIDTH-1:0]  data_load,
   output logic [WIDTH-1:0]  count_out,
   output logic              max_count,
   output logic              zero,
   output logic              at_min,
   output logic              ovf,
   output logic              unf,
   output logic              done,
   output logic              cfg_err
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_d;
   logic             ovf_d, unf_d;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] nxt_val;
   logic             nxt_up, nxt_dn, nxt_done;

   bounded_counter_next #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_next (
      .count    (count_out),
      .step     (step),
      .up_down  (up_down),
      .mode     (mode),
      .lo_bound (lo_bound),
      .hi_bound (hi_bound),
      .next_val (nxt_val),
      .up_cross (nxt_up),
      .dn_cross (nxt_dn),
      .to_done  (nxt_done)
   );

   always_comb begin
      cfg_err   = (lo_bound > hi_bound);
      max_count = (count_out == hi_bound);
      zero      = (count_out == '0);
      at_min    = (count_out == lo_bound);
      done      = (state_q == ST_DONE);

      if (data_load < lo_bound)
         load_val = lo_bound;
      else if (data_load > hi_bound)
         load_val = hi_bound;
      else
         load_val = data_load;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_out;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;

      if (!load_n) begin
         count_d = load_val;
         state_d = ST_RUN;
      end else if (!cfg_err && ce && state_q == ST_RUN) begin
         count_d = nxt_val;
         ovf_d   = nxt_up;
         unf_d   = nxt_dn;
         if (nxt_done)
            state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         count_out <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_out <= count_d;
         ovf       <= ovf_d;
         unf       <= unf_d;
      end
   end

   a_load_in_bounds: assert property (@(posedge clk) disable iff (rst)
      (!load_n && !cfg_err) |=> (count_out >= $past(lo_bound) && count_out <= $past(hi_bound)));

   a_ovf_unf_excl: assert property (@(posedge clk) disable iff (rst)
      !(ovf && unf));

   a_done_stable: assert property (@(posedge clk) disable iff (rst)
      (done && load_n) |=> $stable(count_out));

endmodule

// File: tb/tb_bounded_counter.sv
// Table-driven scoreboard bench for bounded_counter at WIDTH=4, STEP_W=4.
module tb_bounded_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce = 1'b0;
   logic       load_n = 1'b1;
   logic       up_down = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [3:0] step = 4'd0;
   logic [3:0] lo_bound = 4'd2;
   logic [3:0] hi_bound = 4'd12;
   logic [3:0] data_load = 4'd0;
   logic [3:0] count_out;
   logic       max_count, zero, at_min, ovf, unf, done, cfg_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bounded_counter #(.WIDTH(4), .STEP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .load_n    (load_n),
      .up_down   (up_down),
      .mode      (mode),
      .step      (step),
      .lo_bound  (lo_bound),
      .hi_bound  (hi_bound),
      .data_load (data_load),
      .count_out (count_out),
      .max_count (max_count),
      .zero      (zero),
      .at_min    (at_min),
      .ovf       (ovf),
      .unf       (unf),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   typedef struct {
      logic       r, c, ln, ud;
      logic [1:0] m;
      logic [3:0] st, lo, hi, dl;
      logic [3:0] exp_cnt;
      logic [6:0] exp_flg;   // {max, zero, at_min, ovf, unf, done, cfg_err}
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] cnt;
      logic [6:0] flg;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic void add(input logic r, c, ln, ud, input logic [1:0] m,
                               input logic [3:0] st, lo, hi, dl, ec, input logic [6:0] ef);
      vec_t v;
      v.r = r; v.c = c; v.ln = ln; v.ud = ud; v.m = m;
      v.st = st; v.lo = lo; v.hi = hi; v.dl = dl;
      v.exp_cnt = ec; v.exp_flg = ef;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp_v);
      end
   endtask

   initial begin
      exp_t e;
      logic [6:0] f;

      //   r  ce ln ud mode  st  lo  hi  dl   cnt  flags
      add(1, 0, 1, 1, 2'd0, 0,  2, 12, 0,   0, 7'b0100000); // 0 reset
      add(0, 0, 0, 1, 2'd0, 0,  2, 12, 4,   4, 7'b0000000); // 1 load 4
      add(0, 1, 1, 1, 2'd0, 3,  2, 12, 0,   7, 7'b0000000); // 2 count to 7
      add(1, 1, 1, 1, 2'd0, 3,  2, 12, 0,   0, 7'b0100000); // 3 reset mid-count
      add(0, 0, 0, 1, 2'd0, 3,  2, 12, 9,   9, 7'b0000000); // 4 load 9
      add(0, 1, 1, 1, 2'd0, 3,  2, 12, 0,  12, 7'b1000000); // 5 reach hi
      add(0, 1, 1, 1, 2'd0, 3,  2, 12, 0,   2, 7'b0011000); // 6 wrap, ovf
      add(0, 0, 1, 1, 2'd0, 3,  2, 12, 0,   2, 7'b0010000); // 7 ovf one cycle
      add(0, 0, 0, 0, 2'd1, 5,  2, 12, 4,   4, 7'b0000000); // 8 load 4 SAT
      add(0, 1, 1, 0, 2'd1, 5,  2, 12, 0,   2, 7'b0010100); // 9 borrow -> lo, unf
      add(0, 1, 1, 0, 2'd1, 5,  2, 12, 0,   2, 7'b0010100); // 10 repeated unf
      add(0, 1, 1, 0, 2'd1, 5,  2, 12, 0,   2, 7'b0010100); // 11
      add(0, 0, 1, 0, 2'd1, 5,  2, 12, 0,   2, 7'b0010000); // 12 ce off
      add(0, 0, 0, 1, 2'd2, 4,  2, 12, 10, 10, 7'b0000000); // 13 load 10 ONESHOT
      add(0, 1, 1, 1, 2'd2, 4,  2, 12, 0,  12, 7'b1001010); // 14 -> DONE
      for (int i = 0; i < 5; i++)
         add(0, 1, 1, 1, 2'd2, 4, 2, 12, 0, 12, 7'b1000010); // 15..19 hold in DONE
      add(0, 0, 0, 1, 2'd2, 4,  2, 12, 5,   5, 7'b0000000); // 20 load exits DONE
      add(0, 0, 0, 1, 2'd0, 1,  2, 12, 15, 12, 7'b1000000); // 21 load clamped
      add(0, 1, 1, 1, 2'd0, 1, 13,  3, 0,  12, 7'b0000001); // 22 cfg_err holds
      add(0, 1, 1, 1, 2'd0, 1, 13,  3, 0,  12, 7'b0000001); // 23
      add(0, 0, 0, 0, 2'd0, 1,  0, 15, 0,   0, 7'b0110000); // 24 load 0 full range
      add(0, 1, 1, 0, 2'd0, 1,  0, 15, 0,  15, 7'b1000100); // 25 borrow wraps to 15
      add(0, 1, 0, 1, 2'd0, 1,  0, 15, 6,   6, 7'b0000000); // 26 load beats ce
      add(0, 1, 1, 1, 2'd0, 0,  2, 12, 0,   6, 7'b0000000); // 27 step 0 holds
      add(0, 1, 1, 1, 2'd1, 4,  2, 12, 0,  10, 7'b0000000); // 28 SAT up
      add(0, 1, 1, 1, 2'd1, 4,  2, 12, 0,  12, 7'b1001000); // 29 saturate, ovf
      add(0, 1, 1, 1, 2'd1, 4,  2, 12, 0,  12, 7'b1001000); // 30 repeated ovf
      add(0, 1, 1, 1, 2'd3, 4,  2, 12, 0,  12, 7'b1001000); // 31 reserved = SAT
      add(0, 0, 1, 1, 2'd1, 1,  2,  8, 0,  12, 7'b0000000); // 32 hi drops below count
      add(0, 1, 1, 1, 2'd1, 1,  2,  8, 0,   8, 7'b1001000); // 33 next step resolves
      add(0, 0, 0, 0, 2'd2, 10, 2, 12, 11, 11, 7'b0000000); // 34 load 11 ONESHOT
      add(0, 1, 1, 0, 2'd2, 10, 2, 12, 0,   2, 7'b0010110); // 35 down -> DONE
      add(0, 1, 1, 0, 2'd0, 10, 2, 12, 0,   2, 7'b0010010); // 36 mode change stays DONE
      add(1, 1, 1, 0, 2'd0, 10, 2, 12, 0,   0, 7'b0100000); // 37 reset from DONE

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].r; ce = vecs[i].c; load_n = vecs[i].ln; up_down = vecs[i].ud;
         mode = vecs[i].m; step = vecs[i].st; lo_bound = vecs[i].lo;
         hi_bound = vecs[i].hi; data_load = vecs[i].dl;
         e.idx = i; e.cnt = vecs[i].exp_cnt; e.flg = vecs[i].exp_flg;
         sb.push_back(e);

         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard empty at vec %0d", i);
         end else begin
            e = sb.pop_front();
            f = e.flg;
            check("count_out", e.idx, 32'(count_out), 32'(e.cnt));
            check("max_count", e.idx, 32'(max_count), 32'(f[6]));
            check("zero",      e.idx, 32'(zero),      32'(f[5]));
            check("at_min",    e.idx, 32'(at_min),    32'(f[4]));
            check("ovf",       e.idx, 32'(ovf),       32'(f[3]));
            check("unf",       e.idx, 32'(unf),       32'(f[2]));
            check("done",      e.idx, 32'(done),      32'(f[1]));
            check("cfg_err",   e.idx, 32'(cfg_err),   32'(f[0]));
         end
      end

      // Long SAT dwell: every attempted crossing at the bound must pulse ovf.
      @(negedge clk);
      rst = 1'b0; load_n = 1'b0; ce = 1'b0; mode = 2'd1; up_down = 1'b1;
      step = 4'd7; lo_bound = 4'd2; hi_bound = 4'd12; data_load = 4'd12;
      @(negedge clk);
      load_n = 1'b1; ce = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check("sat_dwell_cnt", 100 + k, 32'(count_out), 32'd12);
         check("sat_dwell_ovf", 100 + k, 32'(ovf), 32'd1);
         check("sat_dwell_unf", 100 + k, 32'(unf), 32'd0);
      end
      @(negedge clk);
      ce = 1'b0;
      @(posedge clk);
      #1;
      check("sat_dwell_ovf_off", 104, 32'(ovf), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bounded_counter.md
BOUNDED_COUNTER -- requirements
Module: bounded_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning count/bound/data width in bits (legal range 2..32).
REQ-002 SHALL have parameter STEP_W, default 4, meaning width of the step input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ce  input  1  count enable.
REQ-006 SHALL have port load_n  input  1  active-low synchronous load.
REQ-007 SHALL have port up_down  input  1  direction select: 1 = up, 0 = down.
REQ-008 SHALL have port mode  input  2  boundary mode: WRAP=0, SAT=1, ONESHOT=2; 3 is reserved and behaves as SAT.
REQ-009 SHALL have port step  input  STEP_W  increment magnitude; 0 means hold.
REQ-010 SHALL have port lo_bound  input  WIDTH  inclusive lower bound.
REQ-011 SHALL have port hi_bound  input  WIDTH  inclusive upper bound.
REQ-012 SHALL have port data_load  input  WIDTH  load value.
REQ-013 SHALL have port count_out  output  WIDTH  registered count.
REQ-014 SHALL have port max_count  output  1  combinational flag, count_out == hi_bound.
REQ-015 SHALL have port zero  output  1  combinational flag, count_out == 0.
REQ-016 SHALL have port at_min  output  1  combinational flag, count_out == lo_bound.
REQ-017 SHALL have port ovf  output  1  registered one-cycle pulse on an upper-bound crossing.
REQ-018 SHALL have port unf  output  1  registered one-cycle pulse on a lower-bound crossing.
REQ-019 SHALL have port done  output  1  high while the FSM is in DONE.
REQ-020 SHALL have port cfg_err  output  1  combinational flag, lo_bound > hi_bound.

Function
REQ-021 SHALL apply priority rst > load_n low > cfg_err > ce.
REQ-022 SHALL, on a load, set count_out to data_load clamped into [lo_bound, hi_bound], clear done, and return the FSM to RUN.
REQ-023 SHALL hold count_out and suppress ovf/unf while cfg_err=1, unless a load is applied.
REQ-024 SHALL use an FSM with states RUN and DONE; it SHALL change state only in ONESHOT mode or on rst/load.
REQ-025 SHALL compute the next value in WIDTH+1 bits when ce=1 in RUN: up gives count_out+step, down gives count_out-step.
REQ-026 SHALL detect an up crossing when the candidate exceeds hi_bound, and a down crossing when the candidate is below lo_bound or borrows below 0.
REQ-027 SHALL, on an up crossing, load lo_bound in WRAP, hi_bound in SAT, and hi_bound with transition RUN->DONE in ONESHOT; ovf SHALL be 1 the next cycle.
REQ-028 SHALL, on a down crossing, load hi_bound in WRAP, lo_bound in SAT, and lo_bound with transition RUN->DONE in ONESHOT; unf SHALL be 1 the next cycle.
REQ-029 SHALL, in SAT, pulse ovf/unf on every cycle a crossing is attempted while sitting at the bound.
REQ-030 SHALL, in DONE, hold count_out regardless of ce and keep ovf/unf at 0; the FSM SHALL leave DONE only via load or rst.
REQ-031 SHALL load the count with 1-cycle latency; the flags SHALL follow count_out in the same cycle.
REQ-032 SHALL sample mode changes each cycle and leave the count unaffected; a change of mode while in DONE SHALL NOT exit DONE.
REQ-033 SHALL leave count_out unchanged if the bounds change and the count falls outside them, with the next counting step resolving per REQ-026..028.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set count_out=0, ovf=0, unf=0, the FSM to RUN, and done=0.
REQ-035 SHALL give reset priority over load and ce, including when applied mid-count or while in DONE.

Structure
REQ-036 SHALL define the mode enum (WRAP/SAT/ONESHOT), the FSM state enum, and the default WIDTH/STEP_W constants in the shared package.
REQ-037 SHALL place the next-value/crossing calculation in one combinational sub-module, bounded_counter_next; the state, flags, and pulses SHALL live in the top module.
REQ-038 SHALL provide SVA for: count within bounds when cfg_err=0 after a load, ovf and unf never asserted together, and done implying a stable count.

Verification (WIDTH=4, lo=2, hi=12 unless stated)
REQ-039 SHALL cover: rst=1 mid-count at 7 -> next cycle count_out=0, zero=1, done=0, ovf=0.
REQ-040 SHALL cover: load 9, WRAP, up, step=3, ce=1 -> 12 (max_count=1), then 2 with ovf=1 for one cycle.
REQ-041 SHALL cover: load 4, SAT, down, step=5 -> 2 with unf=1, and repeated unf pulses while ce stays high at 2.
REQ-042 SHALL cover: load 10, ONESHOT, up, step=4 -> 12, done=1; a further 5 cycles of ce keep 12; load 5 -> 5, done=0.
REQ-043 SHALL cover: load 15 -> 12 (clamped); lo=13, hi=3 -> cfg_err=1 and count holds under ce.
REQ-044 SHALL cover: lo=0, hi=15, WRAP, down, step=1 from 0 -> 15, unf=1; load_n=0 together with ce=1 -> load wins.
